// File: rtl/camera_capmod.sv
// ============================================================================
// camera_capmod
// ----------------------------------------------------------------------------
// Captures a byte-serial RGB565 camera stream (VSYNC/HREF/data, already in
// the CLOCK domain and qualified by a one-cycle pixel-clock enable). Every
// four line bytes are packed into one 36-bit line-buffer word.
//
// Ports
//   CLOCK       system clock, rising edge
//   RESET       asynchronous, active-low reset
//   iPclkEn     qualifier: inputs are sampled only when 1
//   iVSYNC      high = vertical blanking
//   iHREF       high = valid line byte
//   iByte       camera data byte
//   oWrEn       one-cycle word write strobe
//   oData       {0, parity, EOL, SOL, b0, b1, b2, b3}, valid with oWrEn
//   oLineDone   one-cycle pulse after each accepted line
//   oFrameDone  one-cycle pulse after each frame
//   oLine       current line index
//   oErr        sticky line/frame length error
//
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module camera_capmod #(
  parameter logic [9:0] XSIZE = 10'd160,
  parameter logic [9:0] YSIZE = 10'd240
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        iPclkEn,
  input  logic        iVSYNC,
  input  logic        iHREF,
  input  logic [7:0]  iByte,
  output logic        oWrEn,
  output logic [35:0] oData,
  output logic        oLineDone,
  output logic        oFrameDone,
  output logic [9:0]  oLine,
  output logic        oErr
);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2,
    LINE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_vs_q;
  logic        r_hr_q;
  logic [1:0]  r_phase;
  logic [9:0]  r_wcnt;
  logic [23:0] r_bytes;
  logic        r_par;
  logic        r_wr;
  logic [35:0] r_data;
  logic        r_ldone;
  logic        r_fdone;
  logic [9:0]  r_line;
  logic        r_err;

  logic        w_vs_rise;
  logic        w_vs_fall;
  logic        w_hr_fall;
  logic        w_frame_start;
  logic        w_take_byte;
  logic        w_line_end;
  logic        w_abort;
  logic        w_word_ok;
  logic        w_sol;
  logic        w_eol;

  // Edges are judged only between consecutive qualified samples.
  assign w_vs_rise = iPclkEn &  iVSYNC & ~r_vs_q;
  assign w_vs_fall = iPclkEn & ~iVSYNC &  r_vs_q;
  assign w_hr_fall = iPclkEn & ~iHREF  &  r_hr_q;

  // A completed word is written only while the line still has room and the
  // line itself lies inside the frame.
  assign w_word_ok = (r_wcnt != XSIZE) && (r_line < YSIZE);
  assign w_sol     = (r_wcnt == 10'd0);
  assign w_eol     = (r_wcnt == (XSIZE - 10'd1));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state <= SYNC;
    end else begin
      r_state <= w_next;
    end
  end

  // VSYNC handling is tested first in ACTIVE/LINE so that it wins over any
  // HREF event sampled in the same qualified cycle.
  always_comb begin
    w_next        = r_state;
    w_frame_start = 1'b0;
    w_take_byte   = 1'b0;
    w_line_end    = 1'b0;
    w_abort       = 1'b0;
    case (r_state)
      SYNC: begin
        if (w_vs_rise) w_next = VBLANK;
      end
      VBLANK: begin
        if (w_vs_fall) begin
          w_next        = ACTIVE;
          w_frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_vs_rise) begin
          w_next  = VBLANK;
          w_abort = 1'b1;
        end else if (iPclkEn && iHREF) begin
          w_next      = LINE;
          w_take_byte = 1'b1;
        end
      end
      LINE: begin
        if (w_vs_rise) begin
          w_next  = VBLANK;
          w_abort = 1'b1;
        end else if (w_hr_fall) begin
          w_next     = ACTIVE;
          w_line_end = 1'b1;
        end else if (iPclkEn && iHREF) begin
          w_take_byte = 1'b1;
        end
      end
      default: w_next = SYNC;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_vs_q  <= 1'b0;
      r_hr_q  <= 1'b0;
      r_phase <= 2'd0;
      r_wcnt  <= 10'd0;
      r_bytes <= 24'd0;
      r_par   <= 1'b0;
      r_wr    <= 1'b0;
      r_data  <= 36'd0;
      r_ldone <= 1'b0;
      r_fdone <= 1'b0;
      r_line  <= 10'd0;
      r_err   <= 1'b0;
    end else begin
      // Strobes self-clear every cycle, qualified or not.
      r_wr    <= 1'b0;
      r_ldone <= 1'b0;
      r_fdone <= 1'b0;

      if (iPclkEn) begin
        r_vs_q <= iVSYNC;
        r_hr_q <= iHREF;
      end

      if (w_frame_start) begin
        r_line  <= 10'd0;
        r_wcnt  <= 10'd0;
        r_phase <= 2'd0;
      end

      if (w_take_byte) begin
        r_phase <= r_phase + 2'd1;
        case (r_phase)
          2'd0: r_bytes[23:16] <= iByte;
          2'd1: r_bytes[15:8]  <= iByte;
          2'd2: r_bytes[7:0]   <= iByte;
          2'd3: begin
            // Word counter saturates so over-long lines keep reporting XSIZE.
            if (r_wcnt != XSIZE) r_wcnt <= r_wcnt + 10'd1;
            if (w_word_ok) begin
              r_wr   <= 1'b1;
              r_data <= {1'b0, r_par, w_eol, w_sol, r_bytes, iByte};
            end
          end
          default: ;
        endcase
      end

      // End of line: any partial word is simply dropped by clearing phase.
      if (w_line_end) begin
        r_phase <= 2'd0;
        r_wcnt  <= 10'd0;
        if ((r_wcnt != XSIZE) || (r_phase != 2'd0)) r_err <= 1'b1;
        if (r_line < YSIZE) begin
          r_ldone <= 1'b1;
          r_line  <= r_line + 10'd1;
        end
      end

      // VSYNC during a frame ends it; a partial line produces nothing more.
      if (w_abort) begin
        r_phase <= 2'd0;
        r_wcnt  <= 10'd0;
        if (r_line != 10'd0) begin
          r_fdone <= 1'b1;
          r_par   <= ~r_par;
        end
        if (r_line != YSIZE) r_err <= 1'b1;
      end
    end
  end

  assign oWrEn      = r_wr;
  assign oData      = r_data;
  assign oLineDone  = r_ldone;
  assign oFrameDone = r_fdone;
  assign oLine      = r_line;
  assign oErr       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_camera_capmod.sv
// ============================================================================
// tb_camera_capmod
// ----------------------------------------------------------------------------
// Self-checking bench for camera_capmod, run with a reduced frame geometry.
// Random bytes and random enable gaps drive the DUT; a line/frame-level
// model predicts the written words, strobe counts, line index and error.
//
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_camera_capmod;

  localparam int XS = 8;
  localparam int YS = 6;

  logic        CLOCK   = 1'b0;
  logic        RESET   = 1'b1;
  logic        iPclkEn = 1'b0;
  logic        iVSYNC  = 1'b0;
  logic        iHREF   = 1'b0;
  logic [7:0]  iByte   = 8'h00;
  logic        oWrEn;
  logic [35:0] oData;
  logic        oLineDone;
  logic        oFrameDone;
  logic [9:0]  oLine;
  logic        oErr;

  camera_capmod #(
    .XSIZE(10'(XS)),
    .YSIZE(10'(YS))
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .iPclkEn   (iPclkEn),
    .iVSYNC    (iVSYNC),
    .iHREF     (iHREF),
    .iByte     (iByte),
    .oWrEn     (oWrEn),
    .oData     (oData),
    .oLineDone (oLineDone),
    .oFrameDone(oFrameDone),
    .oLine     (oLine),
    .oErr      (oErr)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  // Observed DUT activity.
  logic [35:0] q_got[$];
  int          got_ld = 0;
  int          got_fd = 0;

  // Reference model state.
  logic [35:0] q_exp[$];
  logic [7:0]  q_line[$];
  int          exp_ld = 0;
  int          exp_fd = 0;
  int          m_line = 0;
  bit          m_par  = 1'b0;
  bit          m_err  = 1'b0;

  always @(negedge CLOCK) begin
    if (oWrEn === 1'b1)      q_got.push_back(oData);
    if (oLineDone === 1'b1)  got_ld++;
    if (oFrameDone === 1'b1) got_fd++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got=timeout required=finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------- drivers
  // Random number of unqualified cycles carrying noise, then one qualified one.
  task automatic qsample(input bit vs, input bit hr, input logic [7:0] b, input int maxgap);
    int g;
    g = int'($urandom_range(maxgap, 0));
    for (int i = 0; i < g; i++) begin
      @(negedge CLOCK);
      iPclkEn = 1'b0;
      iVSYNC  = 1'($urandom);
      iHREF   = 1'($urandom);
      iByte   = 8'($urandom);
    end
    @(negedge CLOCK);
    iPclkEn = 1'b1;
    iVSYNC  = vs;
    iHREF   = hr;
    iByte   = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK);
      iPclkEn = 1'b0;
    end
    #1;
  endtask

  task automatic vs_rise();
    qsample(1'b1, 1'b0, 8'h00, 2);
    qsample(1'b1, 1'b0, 8'h00, 2);
  endtask

  task automatic vs_fall();
    qsample(1'b0, 1'b0, 8'h00, 2);
    qsample(1'b0, 1'b0, 8'h00, 2);
  endtask

  // n HREF bytes followed by the HREF falling edge.
  task automatic send_line(input int n, input int maxgap);
    logic [7:0] b;
    q_line.delete();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      q_line.push_back(b);
      qsample(1'b0, 1'b1, b, maxgap);
    end
    qsample(1'b0, 1'b0, 8'h00, maxgap);
    qsample(1'b0, 1'b0, 8'h00, maxgap);
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RESET   = 1'b0;
    iPclkEn = 1'b0;
    iVSYNC  = 1'b0;
    iHREF   = 1'b0;
    repeat (3) @(negedge CLOCK);
    RESET = 1'b1;
    q_got.delete();
    q_exp.delete();
    got_ld = 0; got_fd = 0;
    exp_ld = 0; exp_fd = 0;
    m_line = 0; m_par = 1'b0; m_err = 1'b0;
  endtask

  // ------------------------------------------------------------------ model
  // Line in q_line: words are groups of four bytes, at most XS per line,
  // written only for lines inside the frame. An aborted line keeps its
  // completed words but neither ends the line nor moves the line index.
  task automatic model_line(input bit aborted);
    int          nw;
    logic [35:0] wd;
    nw = q_line.size() / 4;
    if (nw > XS) nw = XS;
    if (m_line < YS) begin
      for (int w = 0; w < nw; w++) begin
        wd = {1'b0, m_par, (w == XS - 1) ? 1'b1 : 1'b0, (w == 0) ? 1'b1 : 1'b0,
              q_line[4*w], q_line[4*w+1], q_line[4*w+2], q_line[4*w+3]};
        q_exp.push_back(wd);
      end
      if (!aborted) exp_ld++;
    end
    if (!aborted) begin
      if ((nw != XS) || ((q_line.size() % 4) != 0)) m_err = 1'b1;
      if (m_line < YS) m_line++;
    end
  endtask

  task automatic model_frame_end();
    if (m_line > 0) begin
      exp_fd++;
      m_par = ~m_par;
    end
    if (m_line != YS) m_err = 1'b1;
    m_line = 0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    repeat (2) @(negedge CLOCK);
    #2;
    RESET = 1'b0;
    #1;
    total++; if (oWrEn !== 1'b0)      begin bad++; $display("FAIL reset_wren got=%b exp=0", oWrEn); end
    total++; if (oData !== 36'd0)     begin bad++; $display("FAIL reset_data got=%h exp=0", oData); end
    total++; if (oLineDone !== 1'b0)  begin bad++; $display("FAIL reset_ldone got=%b exp=0", oLineDone); end
    total++; if (oFrameDone !== 1'b0) begin bad++; $display("FAIL reset_fdone got=%b exp=0", oFrameDone); end
    total++; if (oLine !== 10'd0)     begin bad++; $display("FAIL reset_line got=%0d exp=0", oLine); end
    total++; if (oErr !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b exp=0", oErr); end
    do_reset();
  endtask

  task automatic test_word_pack();
    do_reset();
    vs_rise();
    vs_fall();
    qsample(1'b0, 1'b1, 8'h12, 0);
    qsample(1'b0, 1'b1, 8'h34, 0);
    qsample(1'b0, 1'b1, 8'h56, 0);
    qsample(1'b0, 1'b1, 8'h78, 0);
    @(negedge CLOCK);
    iPclkEn = 1'b0;
    total++; if (oWrEn !== 1'b1) begin bad++; $display("FAIL pack_wren_latency got=%b exp=1", oWrEn); end
    total++; if (oData !== 36'h1_12345678) begin bad++; $display("FAIL pack_data got=%h exp=112345678", oData); end
    @(negedge CLOCK);
    total++; if (oWrEn !== 1'b0) begin bad++; $display("FAIL pack_wren_width got=%b exp=0", oWrEn); end
    idle(2);
    total++; if (q_got.size() !== 1) begin bad++; $display("FAIL pack_nwrites got=%0d exp=1", q_got.size()); end
  endtask

  task automatic test_nominal();
    do_reset();
    vs_rise();
    vs_fall();
    for (int l = 0; l <= YS; l++) begin
      send_line(4 * XS, 2);
      model_line(1'b0);
    end
    idle(3);
    total++; if (oLine !== 10'(m_line)) begin bad++; $display("FAIL nom_line got=%0d exp=%0d", oLine, m_line); end
    total++; if (got_ld !== exp_ld) begin bad++; $display("FAIL nom_ldone got=%0d exp=%0d", got_ld, exp_ld); end
    total++; if (oErr !== m_err) begin bad++; $display("FAIL nom_err got=%b exp=%b", oErr, m_err); end
    vs_rise();
    model_frame_end();
    idle(3);
    total++; if (got_fd !== exp_fd) begin bad++; $display("FAIL nom_fdone got=%0d exp=%0d", got_fd, exp_fd); end
    total++; if (oErr !== m_err) begin bad++; $display("FAIL nom_err_frame got=%b exp=%b", oErr, m_err); end
    vs_fall();
    send_line(4 * XS, 1);
    model_line(1'b0);
    idle(3);
    total++; if (q_got.size() !== q_exp.size()) begin bad++; $display("FAIL nom_nwrites got=%0d exp=%0d", q_got.size(), q_exp.size()); end
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
      total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL nom_word[%0d] got=%h exp=%h", i, q_got[i], q_exp[i]); end
    end
  endtask

  task automatic test_line_length();
    do_reset();
    vs_rise();
    vs_fall();
    send_line(4 * XS + 4, 1);
    model_line(1'b0);
    idle(3);
    total++; if (q_got.size() !== XS) begin bad++; $display("FAIL len_long_nwrites got=%0d exp=%0d", q_got.size(), XS); end
    total++; if (q_got[XS-1][33] !== 1'b1) begin bad++; $display("FAIL len_long_eol got=%b exp=1", q_got[XS-1][33]); end
    total++; if (oErr !== m_err) begin bad++; $display("FAIL len_long_err got=%b exp=%b", oErr, m_err); end
    send_line(4 * XS - 2, 1);
    model_line(1'b0);
    idle(3);
    total++; if (q_got.size() !== 2 * XS - 1) begin bad++; $display("FAIL len_short_nwrites got=%0d exp=%0d", q_got.size(), 2 * XS - 1); end
    total++; if (oErr !== m_err) begin bad++; $display("FAIL len_short_err got=%b exp=%b", oErr, m_err); end
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
      total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL len_word[%0d] got=%h exp=%h", i, q_got[i], q_exp[i]); end
    end
    do_reset();
    vs_rise();
    vs_fall();
    send_line(4 * XS + 2, 1);
    model_line(1'b0);
    idle(3);
    total++; if (q_got.size() !== XS) begin bad++; $display("FAIL len_odd_nwrites got=%0d exp=%0d", q_got.size(), XS); end
    total++; if (oErr !== m_err) begin bad++; $display("FAIL len_odd_err got=%b exp=%b", oErr, m_err); end
  endtask

  task automatic test_vsync_abort();
    logic [7:0] b;
    do_reset();
    vs_rise();
    vs_fall();
    for (int l = 0; l < 3; l++) begin
      send_line(4 * XS, 2);
      model_line(1'b0);
    end
    q_line.delete();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      q_line.push_back(b);
      qsample(1'b0, 1'b1, b, 1);
    end
    // VSYNC rises on a sample that still has HREF high.
    qsample(1'b1, 1'b1, 8'hA5, 1);
    model_line(1'b1);
    model_frame_end();
    qsample(1'b1, 1'b0, 8'h00, 1);
    idle(3);
    total++; if (got_ld !== exp_ld) begin bad++; $display("FAIL abort_ldone got=%0d exp=%0d", got_ld, exp_ld); end
    total++; if (got_fd !== exp_fd) begin bad++; $display("FAIL abort_fdone got=%0d exp=%0d", got_fd, exp_fd); end
    total++; if (oErr !== m_err) begin bad++; $display("FAIL abort_err got=%b exp=%b", oErr, m_err); end
    vs_fall();
    send_line(4 * XS, 1);
    model_line(1'b0);
    idle(3);
    total++; if (q_got.size() !== q_exp.size()) begin bad++; $display("FAIL abort_nwrites got=%0d exp=%0d", q_got.size(), q_exp.size()); end
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
      total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL abort_word[%0d] got=%h exp=%h", i, q_got[i], q_exp[i]); end
    end
  endtask

  task automatic test_midframe_start();
    do_reset();
    send_line(4 * XS, 1);
    send_line(4 * XS, 1);
    vs_rise();
    // Bytes during blanking must be ignored.
    for (int i = 0; i < 8; i++) qsample(1'b1, 1'b1, 8'($urandom), 1);
    qsample(1'b1, 1'b0, 8'h00, 1);
    idle(3);
    total++; if (q_got.size() !== 0) begin bad++; $display("FAIL mid_prewrites got=%0d exp=0", q_got.size()); end
    total++; if (got_ld !== 0) begin bad++; $display("FAIL mid_preldone got=%0d exp=0", got_ld); end
    vs_fall();
    send_line(4 * XS, 2);
    model_line(1'b0);
    idle(3);
    total++; if (q_got.size() !== q_exp.size()) begin bad++; $display("FAIL mid_nwrites got=%0d exp=%0d", q_got.size(), q_exp.size()); end
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
      total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL mid_word[%0d] got=%h exp=%h", i, q_got[i], q_exp[i]); end
    end
    total++; if (oLine !== 10'(m_line)) begin bad++; $display("FAIL mid_line got=%0d exp=%0d", oLine, m_line); end
  endtask

  task automatic test_reset_midline();
    int n_before;
    do_reset();
    vs_rise();
    vs_fall();
    send_line(4 * XS, 1);
    for (int i = 0; i < 10; i++) qsample(1'b0, 1'b1, 8'($urandom), 1);
    @(negedge CLOCK);
    iPclkEn = 1'b0;
    #2;
    n_before = q_got.size();
    total++; if (n_before !== XS + 2) begin bad++; $display("FAIL rst_prewrites got=%0d exp=%0d", n_before, XS + 2); end
    RESET = 1'b0;
    #1;
    total++; if (oLine !== 10'd0) begin bad++; $display("FAIL rst_async_line got=%0d exp=0", oLine); end
    total++; if (oData !== 36'd0) begin bad++; $display("FAIL rst_async_data got=%h exp=0", oData); end
    for (int i = 0; i < 6; i++) qsample(1'b0, 1'b1, 8'($urandom), 0);
    @(negedge CLOCK);
    RESET = 1'b1;
    for (int i = 0; i < 6; i++) qsample(1'b0, 1'b1, 8'($urandom), 0);
    qsample(1'b0, 1'b0, 8'h00, 0);
    send_line(4 * XS, 1);
    idle(3);
    total++; if (q_got.size() !== n_before) begin bad++; $display("FAIL rst_no_writes got=%0d exp=%0d", q_got.size(), n_before); end
    total++; if (got_ld !== 1) begin bad++; $display("FAIL rst_no_ldone got=%0d exp=1", got_ld); end
    q_got.delete();
    q_exp.delete();
    m_line = 0; m_par = 1'b0; m_err = 1'b0;
    vs_rise();
    vs_fall();
    send_line(4 * XS, 1);
    model_line(1'b0);
    idle(3);
    total++; if (q_got.size() !== q_exp.size()) begin bad++; $display("FAIL rst_nwrites got=%0d exp=%0d", q_got.size(), q_exp.size()); end
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
      total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL rst_word[%0d] got=%h exp=%h", i, q_got[i], q_exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_word_pack();
    test_nominal();
    test_line_length();
    test_vsync_abort();
    test_midframe_start();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
